// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-cycle ALU sequencers: FSM encoding and
// the word-counter width helper.
package alu_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Word counter needs at least one bit even for single-word operations.
    function automatic int cnt_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// Operand/result bus of the wide add/subtract sequencer.
// A transfer happens on a rising edge where valid and ready are both high;
// the source holds its payload stable from asserting valid until that edge.
interface wide_add_seq_if #(
    parameter int N     = 8,
    parameter int WORDS = 4
) ();
    localparam int W = N * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/parallel_prefix_tree.sv
// N-bit Kogge-Stone carry-prefix slice: C_out[i] is the carry out of bit i
// given per-bit generate/propagate and a slice carry-in.
module parallel_prefix_tree #(
    parameter int N = 8
) (
    input  logic [N-1:0] G_in,
    input  logic [N-1:0] P_in,
    input  logic         cin,
    output logic [N-1:0] C_out
);
    logic [N-1:0] g_cur;
    logic [N-1:0] p_cur;
    logic [N-1:0] g_nxt;
    logic [N-1:0] p_nxt;

    always_comb begin
        g_cur    = G_in;
        p_cur    = P_in;
        // Folding cin into bit 0 makes every prefix carry include it.
        g_cur[0] = G_in[0] | (P_in[0] & cin);
        g_nxt    = g_cur;
        p_nxt    = p_cur;
        for (int d = 1; d < N; d = d * 2) begin
            g_nxt = g_cur;
            p_nxt = p_cur;
            for (int i = d; i < N; i++) begin
                g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i-d]);
                p_nxt[i] = p_cur[i] & p_cur[i-d];
            end
            g_cur = g_nxt;
            p_cur = p_nxt;
        end
        C_out = g_cur;
    end
endmodule

// File: rtl/wide_add_seq.sv
// WORDS x N-bit add/subtract sequencer: one prefix slice reused per word,
// least significant word first, with a registered inter-word carry.
module wide_add_seq
    import alu_seq_pkg::*;
#(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    wide_add_seq_if.slave       bus,
    output logic [STATE_W-1:0]  state_o
);
    localparam int W  = N * WORDS;
    localparam int CW = cnt_width(WORDS);
    localparam logic [CW-1:0] K_LAST = CW'(WORDS - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] k_q, k_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [N-1:0]  g_w, p_w, c_w, sum_word;
    logic [W-1:0]  sum_shift;
    logic          last_word;

    assign g_w       = a_q[N-1:0] & b_q[N-1:0];
    assign p_w       = a_q[N-1:0] ^ b_q[N-1:0];
    assign sum_word  = p_w ^ {c_w[N-2:0], carry_q};
    assign last_word = (k_q == K_LAST);

    parallel_prefix_tree #(.N(N)) u_slice (
        .G_in  (g_w),
        .P_in  (p_w),
        .cin   (carry_q),
        .C_out (c_w)
    );

    // New word enters at the top so word 0 ends up at the bottom after WORDS shifts.
    if (WORDS == 1) begin : g_sum_one
        assign sum_shift = sum_word;
    end else begin : g_sum_many
        assign sum_shift = {sum_word, sum_q[W-1:N]};
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_RUN;
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    k_d     = '0;
                    sum_d   = '0;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> N;
                b_d     = b_q >> N;
                sum_d   = sum_shift;
                carry_d = c_w[N-1];
                if (last_word) begin
                    cout_d  = c_w[N-1];
                    ovf_d   = c_w[N-1] ^ c_w[N-2];
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// Directed + random bench for wide_add_seq (N=8, WORDS=4) with a result scoreboard.
module tb_wide_add_seq;
    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic       clk;
    logic       rst;
    logic [1:0] state_o;
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;

    logic [W+1:0] exp_q[$];

    wide_add_seq_if #(.N(N), .WORDS(WORDS)) bus ();

    wide_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    // Independent reference: full-width add with the two's-complement rule for ovf.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic s);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         ov;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : ci)};
        ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {full[W], ov, full[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [W+1:0] got, input logic [W+1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard side: compare when the DUT's result transfers on the next edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {bus.cout, bus.ovf, bus.sum}, 'x);
            end else begin
                check("result", {bus.cout, bus.ovf, bus.sum}, exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic s, input logic [W+1:0] exp);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) check("in_ready_timeout", 1'b0, 1'b1);
        bus.a = a; bus.b = b; bus.cin = ci; bus.sub = s; bus.in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.cin = ~ci; bus.sub = ~s;
    endtask

    task automatic do_op_m(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                           input logic s);
        do_op(a, b, ci, s, model(a, b, ci, s));
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) check("drain_timeout", W'(exp_q.size()), '0);
    endtask

    initial begin
        logic [W-1:0] held;
        int lat;
        int last_acc;
        int nacc;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_sum", bus.sum, '0);
        check("rst_flags", {bus.cout, bus.ovf}, 2'b00);
        check("rst_state", state_o, 2'd0);
        @(posedge clk); #1;

        // Simple add; out_valid must appear WORDS edges after the accept edge.
        do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, {2'b00, 32'h00000100});
        check("run_in_ready", bus.in_ready, 1'b0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("latency_edges", lat, WORDS);
        drain();

        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, {2'b10, 32'h00000000});
        drain();
        do_op(32'h80000000, 32'h00000001, 1'b1, 1'b1, {2'b11, 32'h7FFFFFFF});
        drain();

        // Held result under backpressure; a new request meanwhile is ignored.
        bus.out_ready = 1'b0;
        do_op(32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, {2'b01, 32'h80000000});
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        held = bus.sum;
        check("held_sum_first", held, 32'h80000000);
        bus.in_valid = 1'b1; bus.a = 32'h11111111; bus.b = 32'h22222222;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_sum", bus.sum, held);
            check("hold_in_ready", bus.in_ready, 1'b0);
            check("hold_out_valid", bus.out_valid, 1'b1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
        drain();

        // Reset in the second RUN cycle aborts the operation silently.
        bus.a = 32'hDEADBEEF; bus.b = 32'h01010101; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", bus.in_ready, 1'b1);
        check("abort_out_valid", bus.out_valid, 1'b0);
        bus.out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, {2'b00, 32'h23456789});
        drain();

        for (int i = 0; i < 6; i++) begin
            do_op_m($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drain();
        end
        do_op_m(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        drain();

        // Back-to-back with both valid and ready tied high.
        bus.out_ready = 1'b1;
        bus.a = $urandom; bus.b = $urandom; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        last_acc = -1;
        nacc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
                if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, WORDS + 2);
                last_acc = cyc;
                nacc++;
            end
            @(posedge clk); #1;
            bus.a = $urandom; bus.b = $urandom;
            bus.cin = 1'($urandom_range(0, 1)); bus.sub = 1'($urandom_range(0, 1));
        end
        bus.in_valid = 1'b0;
        check("b2b_count", nacc, 7);
        drain();
        repeat (10) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
